// File: rtl/acc_sample_scheduler_pkg.sv
// Shared state type, widths and helpers for the accelerometer sample scheduler.
package acc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WAIT_TICK,
        ST_WAIT_READ
    } acc_state_e;

    localparam int AXIS_W = 16;
    localparam int SEQ_W  = 8;
    localparam int CNT_W  = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/acc_sample_scheduler_if.sv
// Bundle between the sample scheduler, the SPI wrapper and the downstream pipeline.
interface acc_sample_scheduler_if;
    import acc_ctrl_pkg::*;

    logic                     enable;
    logic                     clear_err;
    logic                     acc_done_init;
    logic                     acc_done_read;
    logic signed [AXIS_W-1:0] acc_x;
    logic signed [AXIS_W-1:0] acc_y;
    logic signed [AXIS_W-1:0] acc_z;
    logic                     acc_start;
    logic                     acc_filter_rst;
    logic signed [AXIS_W-1:0] sample_x;
    logic signed [AXIS_W-1:0] sample_y;
    logic signed [AXIS_W-1:0] sample_z;
    logic [SEQ_W-1:0]         sample_seq;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     timeout_err;
    logic [CNT_W-1:0]         drop_cnt;
    logic [CNT_W-1:0]         miss_cnt;
    logic                     busy;

    modport slave (
        input  enable, clear_err, acc_done_init, acc_done_read,
               acc_x, acc_y, acc_z, sample_ready,
        output acc_start, acc_filter_rst, sample_x, sample_y, sample_z,
               sample_seq, sample_valid, timeout_err, drop_cnt, miss_cnt, busy
    );

    modport master (
        output enable, clear_err, acc_done_init, acc_done_read,
               acc_x, acc_y, acc_z, sample_ready,
        input  acc_start, acc_filter_rst, sample_x, sample_y, sample_z,
               sample_seq, sample_valid, timeout_err, drop_cnt, miss_cnt, busy
    );

endinterface

// File: rtl/acc_sample_scheduler_tick_gen.sv
// Sample-rate divider: down-counter with one-cycle tick at terminal count.
module acc_tick_gen #(
    parameter int SAMPLE_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);
    localparam int            CW     = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clear_i || cnt_q == '0) cnt_d = RELOAD;
        else                        cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= RELOAD;
        else     cnt_q <= cnt_d;
    end

    assign tick_o = !clear_i && (cnt_q == '0);

endmodule

// File: rtl/acc_sample_scheduler.sv
// Periodic accelerometer read sequencer with one-deep sample register and error supervision.
//   state        | meaning
//   ST_IDLE      | disabled, divider held clear
//   ST_WAIT_INIT | enabled, waiting for sensor init
//   ST_WAIT_TICK | ready, waiting for the next sample tick
//   ST_WAIT_READ | read requested, waiting for done edge or timeout
module acc_sample_scheduler
    import acc_ctrl_pkg::*;
#(
    parameter int SAMPLE_DIV     = 100000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic                    clk,
    input logic                    rst,
    acc_sample_scheduler_if.slave  bus
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

    acc_state_e               state_q, state_d;
    logic                     start_q, start_d;
    logic                     frst_q, frst_d;
    logic                     done_prev_q;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic signed [AXIS_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [SEQ_W-1:0]         seq_q, seq_d, nseq_q, nseq_d;
    logic                     valid_q, valid_d;
    logic                     terr_q, terr_d;
    logic [CNT_W-1:0]         drop_q, drop_d, miss_q, miss_d;
    logic                     tick, capture, timeout, rd_edge;

    acc_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == ST_IDLE),
        .tick_o  (tick)
    );

    assign rd_edge = bus.acc_done_read && !done_prev_q;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        frst_d  = 1'b0;
        tmo_d   = tmo_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.enable) state_d = ST_WAIT_INIT;
            ST_WAIT_INIT: begin
                if (!bus.enable)           state_d = ST_IDLE;
                else if (bus.acc_done_init) state_d = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (!bus.enable)             state_d = ST_IDLE;
                else if (!bus.acc_done_init) state_d = ST_WAIT_INIT;
                else if (tick) begin
                    state_d = ST_WAIT_READ;
                    start_d = 1'b1;
                    tmo_d   = TMO_LOAD;
                end
            end
            ST_WAIT_READ: begin
                // A read in flight always finishes (or times out) before honouring disable.
                if (rd_edge) begin
                    capture = 1'b1;
                    state_d = bus.enable ? ST_WAIT_TICK : ST_IDLE;
                end else if (tmo_q == '0) begin
                    timeout = 1'b1;
                    frst_d  = 1'b1;
                    state_d = bus.enable ? ST_WAIT_TICK : ST_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        seq_d   = seq_q;
        nseq_d  = nseq_q;
        valid_d = valid_q;
        terr_d  = terr_q;
        drop_d  = drop_q;
        miss_d  = miss_q;

        if (valid_q && bus.sample_ready) valid_d = 1'b0;
        if (capture) begin
            if (!valid_q || bus.sample_ready) begin
                x_d     = bus.acc_x;
                y_d     = bus.acc_y;
                z_d     = bus.acc_z;
                seq_d   = nseq_q;
                nseq_d  = nseq_q + SEQ_W'(1);
                valid_d = 1'b1;
            end else begin
                drop_d = sat_inc(drop_q);
            end
        end
        if (timeout) terr_d = 1'b1;
        if (tick && state_q == ST_WAIT_READ) miss_d = sat_inc(miss_q);
        if (bus.clear_err) begin
            terr_d = 1'b0;
            drop_d = '0;
            miss_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            frst_q      <= 1'b0;
            done_prev_q <= 1'b0;
            tmo_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            seq_q       <= '0;
            nseq_q      <= '0;
            valid_q     <= 1'b0;
            terr_q      <= 1'b0;
            drop_q      <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            frst_q      <= frst_d;
            done_prev_q <= bus.acc_done_read;
            tmo_q       <= tmo_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            seq_q       <= seq_d;
            nseq_q      <= nseq_d;
            valid_q     <= valid_d;
            terr_q      <= terr_d;
            drop_q      <= drop_d;
            miss_q      <= miss_d;
        end
    end

    assign bus.acc_start      = start_q;
    assign bus.acc_filter_rst = frst_q;
    assign bus.sample_x       = x_q;
    assign bus.sample_y       = y_q;
    assign bus.sample_z       = z_q;
    assign bus.sample_seq     = seq_q;
    assign bus.sample_valid   = valid_q;
    assign bus.timeout_err    = terr_q;
    assign bus.drop_cnt       = drop_q;
    assign bus.miss_cnt       = miss_q;
    assign bus.busy           = (state_q == ST_WAIT_READ);

endmodule

// File: doc/acc_sample_scheduler.md
# acc_sample_scheduler

Sequences the accelerometer SPI interface wrapper at a fixed sample rate: waits for sensor init, issues periodic one-cycle start pulses, detects read completion, and latches x/y/z into a one-deep output register with a valid/ready handshake toward the gesture/Bluetooth pipeline. It also supervises read timeouts and counts dropped samples and missed sample ticks.

## Interface
Parameters:
- SAMPLE_DIV, 100000: clk cycles per sample tick (≥ 4).
- TIMEOUT_CYCLES, 50000: maximum cycles in WAIT_READ before abort (≥ 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; level.
- clear_err  in  1  one-cycle pulse; clears timeout_err, drop_cnt, miss_cnt.
- acc_done_init  in  1  sensor init complete; level.
- acc_done_read  in  1  read complete; level, sampled for a rising edge.
- acc_x / acc_y / acc_z  in  16 signed each  axis data; valid while acc_done_read is high.
- acc_start  out  1  one-cycle read request to the wrapper.
- acc_filter_rst  out  1  one-cycle pulse on timeout.
- sample_x / sample_y / sample_z  out  16 signed each  latched sample.
- sample_seq  out  8  sample sequence number; wraps 255→0.
- sample_valid  out  1  output register holds an unconsumed sample.
- sample_ready  in  1  downstream accepts when valid && ready.
- timeout_err  out  1  sticky.
- drop_cnt  out  8  samples discarded because the output register was full; saturates at 255.
- miss_cnt  out  8  ticks missed while a read was in flight; saturates at 255.
- busy  out  1  high in WAIT_READ.

## Operation
- States: IDLE, WAIT_INIT, WAIT_TICK, WAIT_READ.
- IDLE: enable=1 → WAIT_INIT.
- WAIT_INIT: acc_done_init=1 → WAIT_TICK; enable=0 → IDLE.
- WAIT_TICK:
  - enable=0 → IDLE.
  - Else acc_done_init=0 → WAIT_INIT.
  - Else tick → WAIT_READ, with acc_start=1 for exactly one cycle.
- WAIT_READ:
  - Rising edge of acc_done_read (current=1, registered previous=0) → capture, then → WAIT_TICK. If enable=0, the current read completes or times out first, then → IDLE.
  - Timeout counter reaches TIMEOUT_CYCLES → set timeout_err, pulse acc_filter_rst, no capture, → WAIT_TICK.
- Tick generator: counts 0..SAMPLE_DIV-1 while state ≠ IDLE; tick=1 at terminal count; clears in IDLE. A tick in WAIT_READ increments miss_cnt and is not queued.
- Capture:
  - sample_valid=0 → load x/y/z and sample_seq, set valid.
  - valid && ready in the same cycle → load the new sample; valid stays 1; no drop.
  - valid && !ready → keep the old sample, increment drop_cnt.
  - sample_seq increments on every successful capture only.
- Handshake: valid && ready with no capture → valid clears next cycle. Data is stable while valid && !ready.
- clear_err coinciding with an increment or set: clear wins.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including sample_*, sample_seq, counters and flags.
  - acc_done_read edge register cleared.
- Tick in WAIT_TICK at cycle T → acc_start=1 and busy=1 at T+1 (registered outputs).
- acc_done_read edge at cycle R → sample_* and sample_valid updated at R+1; WAIT_TICK at R+1.
- Timeout: TIMEOUT_CYCLES cycles after entering WAIT_READ → acc_filter_rst=1 and timeout_err=1 on the next cycle.
- acc_done_read already high on entry to WAIT_READ is not an edge; the block waits for a low→high transition.
- Reset mid-read: immediate return to IDLE; an in-flight result arriving after reset is ignored.

## Structure
- Package acc_ctrl_pkg holds:
  - the state enum;
  - AXIS_W=16, SEQ_W=8, CNT_W=8;
  - a saturating-increment function.
- Sub-module acc_tick_gen implements the SAMPLE_DIV divider with clear input and tick output.
- The FSM, edge detect, timeout counter and output register live in the top module.

## Test plan
- Reset then enable with done_init=1, SAMPLE_DIV=100 → acc_start pulses every 100 cycles, exactly 1 cycle wide; all outputs 0 before enable.
- Done_read rises 20 cycles after start with x=0x1234, y=-5, z=0x7FFF, ready=1 → sample_* match at the next cycle, seq=0 then 1, valid for 1 cycle.
- Hold ready=0 across 3 captures → first sample retained, drop_cnt=2; release ready → valid clears, seq=0 shown.
- TIMEOUT_CYCLES=50, no done_read → acc_filter_rst and timeout_err at cycle 51 after entry; clear_err → timeout_err=0.
- SAMPLE_DIV=10 with reads taking 25 cycles → miss_cnt increments per missed tick and saturates at 255.
- Async reset asserted mid-WAIT_READ, done_read rising after release → no capture, state IDLE, valid=0.
